// File: rtl/fc_pkg.sv
// Shared constants and FSM state type for the FC argmax reader.
package fc_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int NUM_CLASSES = 10;
  localparam int IDX_WIDTH   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fc_argmax_reader_float_compare_gt.sv
// Combinational IEEE-754 strict greater-than (a > b). NaN is never greater;
// any non-NaN beats a NaN b. Signed zeros compare equal.
module float_compare_gt #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  a_gt_b
);

  localparam int EW = 8;
  localparam int MW = DATA_WIDTH - EW - 1;

  logic                  a_sign, b_sign;
  logic [DATA_WIDTH-2:0] a_mag, b_mag;
  logic                  a_nan, b_nan;

  assign a_sign = a[DATA_WIDTH-1];
  assign b_sign = b[DATA_WIDTH-1];
  assign a_mag  = a[DATA_WIDTH-2:0];
  assign b_mag  = b[DATA_WIDTH-2:0];
  assign a_nan  = (&a[DATA_WIDTH-2 -: EW]) && (|a[MW-1:0]);
  assign b_nan  = (&b[DATA_WIDTH-2 -: EW]) && (|b[MW-1:0]);

  // Exponent sits above mantissa, so raw magnitude order is numeric order,
  // including Inf as the largest non-NaN magnitude.
  always_comb begin
    a_gt_b = 1'b0;
    if (a_nan)
      a_gt_b = 1'b0;
    else if (b_nan)
      a_gt_b = 1'b1;
    else if (a_mag == '0 && b_mag == '0)
      a_gt_b = 1'b0;
    else if (a_sign != b_sign)
      a_gt_b = !a_sign;
    else if (!a_sign)
      a_gt_b = a_mag > b_mag;
    else
      a_gt_b = a_mag < b_mag;
  end

endmodule

// File: rtl/fc_argmax_reader.sv
// Sequential argmax over a snapshot of the FC output bus, one class per cycle.
// Define FC_ARGMAX_SCORE_OUT_EN to also expose the winning raw word on max_value.
import fc_pkg::*;

module fc_argmax_reader #(
  parameter int DATA_WIDTH  = fc_pkg::DATA_WIDTH,
  parameter int NUM_CLASSES = fc_pkg::NUM_CLASSES
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [NUM_CLASSES*DATA_WIDTH-1:0] fc_output,
  output logic                              busy,
  output logic                              done,
`ifdef FC_ARGMAX_SCORE_OUT_EN
  output logic [DATA_WIDTH-1:0]             max_value,
`endif
  output logic [IDX_WIDTH-1:0]              class_idx
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

  state_t                                state;
  logic [NUM_CLASSES-1:0][DATA_WIDTH-1:0] snap;
  logic [IDX_WIDTH-1:0]                  cnt;
  logic [DATA_WIDTH-1:0]                 max_val;
  logic [IDX_WIDTH-1:0]                  max_idx;

  logic [DATA_WIDTH-1:0] cur;
  logic                  cur_gt;
  logic                  take;
  logic                  last;

  assign cur  = snap[cnt];
  assign last = (cnt == LAST_IDX);
  // Element 0 seeds the running max; later ones need strictly greater,
  // which keeps ties on the lowest index.
  assign take = (cnt == '0) || cur_gt;

  float_compare_gt #(.DATA_WIDTH(DATA_WIDTH)) u_cmp (
    .a      (cur),
    .b      (max_val),
    .a_gt_b (cur_gt)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      snap      <= '0;
      cnt       <= '0;
      max_val   <= '0;
      max_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      class_idx <= '0;
`ifdef FC_ARGMAX_SCORE_OUT_EN
      max_value <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            snap  <= fc_output;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SCAN;
          end else begin
            state <= IDLE;
          end
        end
        SCAN: begin
          if (take) begin
            max_val <= cur;
            max_idx <= cnt;
          end
          // Final element: publish directly so class_idx lands with done.
          if (last) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            class_idx <= take ? cnt : max_idx;
`ifdef FC_ARGMAX_SCORE_OUT_EN
            max_value <= take ? cur : max_val;
`endif
          end else begin
            cnt <= cnt + IDX_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
